// File: rtl/q_stream_monitor.sv
// Watches the Q output of an upstream sequence counter: checks each sample for a legal
// +1 step, locks onto a healthy stream, flags step faults, and reports match/wrap events.
module q_stream_monitor #(
    parameter int unsigned      WIDTH  = 4,
    parameter logic [WIDTH-1:0] MATCH  = 4'b0101,
    parameter int unsigned      LOCK_N = 4,
    parameter int unsigned      CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] q_in,
    input  logic             clr_err,
    output logic             match_p,
    output logic             wrap_p,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] match_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_TRACK  = 2'b01,
        ST_LOCKED = 2'b10,
        ST_FAULT  = 2'b11
    } state_e;

    localparam logic [3:0] LOCK_CNT = 4'(LOCK_N);

    state_e             state_r;
    state_e             state_nxt_s;
    logic [WIDTH-1:0]   prev_r;
    logic [WIDTH-1:0]   prev_nxt_s;
    logic [3:0]         good_cnt_r;
    logic [3:0]         good_cnt_nxt_s;
    logic [3:0]         good_inc_s;
    logic               good_step_s;
    logic               match_hit_s;
    logic               wrap_hit_s;
    logic               cnt_max_s;
    logic               match_p_r;
    logic               wrap_p_r;
    logic               locked_r;
    logic               err_r;
    logic [CNT_W-1:0]   match_cnt_r;

    // A legal step is exactly one above the previous sample, modulo 2^WIDTH.
    function automatic logic is_good_step(input logic [WIDTH-1:0] prev_v,
                                          input logic [WIDTH-1:0] q_v);
        logic [WIDTH-1:0] exp_v;
        exp_v = prev_v + {{(WIDTH-1){1'b0}}, 1'b1};
        return (q_v == exp_v);
    endfunction

    // Event detection for the pulse outputs and the saturating counter.
    always_comb begin
        good_step_s = is_good_step(prev_r, q_in);
        good_inc_s  = good_cnt_r + 4'd1;
        match_hit_s = en & (q_in == MATCH);
        wrap_hit_s  = en & (state_r != ST_IDLE) & (prev_r == {WIDTH{1'b1}})
                         & (q_in == {WIDTH{1'b0}});
        cnt_max_s   = (match_cnt_r == {CNT_W{1'b1}});
    end

    // Next-state logic for the lock FSM, previous sample and good-step counter.
    always_comb begin
        state_nxt_s    = state_r;
        prev_nxt_s     = prev_r;
        good_cnt_nxt_s = good_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (en) begin
                    state_nxt_s    = ST_TRACK;
                    prev_nxt_s     = q_in;
                    good_cnt_nxt_s = 4'd0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_TRACK: begin
                if (en) begin
                    prev_nxt_s = q_in;
                    if (good_step_s) begin
                        good_cnt_nxt_s = good_inc_s;
                        if (good_inc_s == LOCK_CNT) begin
                            state_nxt_s = ST_LOCKED;
                        end else begin
                            state_nxt_s = ST_TRACK;
                        end
                    end else begin
                        good_cnt_nxt_s = 4'd0;
                        state_nxt_s    = ST_TRACK;
                    end
                end else begin
                    state_nxt_s = ST_TRACK;
                end
            end
            ST_LOCKED: begin
                if (en) begin
                    prev_nxt_s = q_in;
                    if (good_step_s) begin
                        state_nxt_s = ST_LOCKED;
                    end else begin
                        state_nxt_s = ST_FAULT;
                    end
                end else begin
                    state_nxt_s = ST_LOCKED;
                end
            end
            ST_FAULT: begin
                // Clearing re-arms tracking; a same-cycle sample only seeds prev.
                if (clr_err) begin
                    state_nxt_s    = ST_TRACK;
                    good_cnt_nxt_s = 4'd0;
                    if (en) begin
                        prev_nxt_s = q_in;
                    end else begin
                        prev_nxt_s = prev_r;
                    end
                end else if (en) begin
                    prev_nxt_s = q_in;
                end else begin
                    prev_nxt_s = prev_r;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                prev_nxt_s     = {WIDTH{1'b0}};
                good_cnt_nxt_s = 4'd0;
            end
        endcase
    end

    // State, history and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            prev_r      <= {WIDTH{1'b0}};
            good_cnt_r  <= 4'd0;
            match_p_r   <= 1'b0;
            wrap_p_r    <= 1'b0;
            locked_r    <= 1'b0;
            err_r       <= 1'b0;
            match_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            prev_r     <= prev_nxt_s;
            good_cnt_r <= good_cnt_nxt_s;
            match_p_r  <= match_hit_s;
            wrap_p_r   <= wrap_hit_s;
            locked_r   <= (state_nxt_s == ST_LOCKED);
            err_r      <= (state_nxt_s == ST_FAULT);
            if (match_hit_s && !cnt_max_s) begin
                match_cnt_r <= match_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign match_p   = match_p_r;
    assign wrap_p    = wrap_p_r;
    assign locked    = locked_r;
    assign err       = err_r;
    assign match_cnt = match_cnt_r;
    assign state     = state_r;

endmodule

// File: tb/tb_q_stream_monitor.sv
// Directed bench for q_stream_monitor: a behavioural stream model checked every cycle,
// plus literal expectations at the key points of each scenario.
`timescale 1ns/100ps
module tb_q_stream_monitor;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] q_in;
    logic       clr_err;
    logic       match_p;
    logic       wrap_p;
    logic       locked;
    logic       err;
    logic [7:0] match_cnt;
    logic [1:0] state;

    int checks;
    int failures;

    // Model: state as 0 idle, 1 tracking, 2 locked, 3 fault.
    int m_state;
    int m_prev;
    int m_good;
    int m_cnt;
    int m_mp;
    int m_wp;

    q_stream_monitor dut (
        .clk(clk), .rst_n(rst_n), .en(en), .q_in(q_in), .clr_err(clr_err),
        .match_p(match_p), .wrap_p(wrap_p), .locked(locked), .err(err),
        .match_cnt(match_cnt), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_prev = 0; m_good = 0; m_cnt = 0; m_mp = 0; m_wp = 0;
    endtask

    task automatic model_edge();
        bit good;
        m_mp = (en && q_in == 4'd5) ? 1 : 0;
        m_wp = (en && m_state != 0 && m_prev == 15 && q_in == 4'd0) ? 1 : 0;
        if (m_mp == 1 && m_cnt < 255) m_cnt++;
        good = (int'(q_in) == (m_prev + 1) % 16);
        if (m_state == 3 && clr_err) begin
            m_state = 1;
            m_good  = 0;
            if (en) m_prev = int'(q_in);
        end else if (en) begin
            if (m_state == 0) begin
                m_state = 1;
                m_good  = 0;
            end else if (m_state == 1) begin
                m_good = good ? m_good + 1 : 0;
                if (m_good == 4) m_state = 2;
            end else if (m_state == 2 && !good) begin
                m_state = 3;
            end
            m_prev = int'(q_in);
        end
    endtask

    task automatic tick(input logic e, input logic [3:0] q, input logic c);
        @(negedge clk);
        en = e; q_in = q; clr_err = c;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        cmp("cyc_state",     32'(state),     32'(m_state));
        cmp("cyc_locked",    32'(locked),    (m_state == 2) ? 32'd1 : 32'd0);
        cmp("cyc_err",       32'(err),       (m_state == 3) ? 32'd1 : 32'd0);
        cmp("cyc_match_p",   32'(match_p),   32'(m_mp));
        cmp("cyc_wrap_p",    32'(wrap_p),    32'(m_wp));
        cmp("cyc_match_cnt", 32'(match_cnt), 32'(m_cnt));
    end

    initial begin
        checks = 0; failures = 0;
        model_reset();
        en = 1'b0; q_in = 4'd0; clr_err = 1'b0; rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #0.5;
        cmp("rst_state", 32'(state), 32'd0);
        cmp("rst_cnt", 32'(match_cnt), 32'd0);
        #0.5 rst_n = 1'b1;

        // Lock-in
        tick(1'b1, 4'd0, 1'b0);
        cmp("lock_track", 32'(state), 32'd1);
        for (int i = 1; i <= 4; i++) tick(1'b1, 4'(i), 1'b0);
        cmp("lock_locked", 32'(locked), 32'd1);
        cmp("lock_err", 32'(err), 32'd0);

        // Match
        tick(1'b1, 4'd5, 1'b0);
        cmp("match_p", 32'(match_p), 32'd1);
        cmp("match_cnt1", 32'(match_cnt), 32'd1);
        tick(1'b1, 4'd6, 1'b0);
        cmp("match_p_end", 32'(match_p), 32'd0);
        cmp("match_locked", 32'(locked), 32'd1);

        // Wrap
        for (int i = 7; i <= 15; i++) tick(1'b1, 4'(i), 1'b0);
        tick(1'b1, 4'd0, 1'b0);
        cmp("wrap_p", 32'(wrap_p), 32'd1);
        cmp("wrap_state", 32'(state), 32'd2);
        tick(1'b1, 4'd1, 1'b0);
        cmp("wrap_p_end", 32'(wrap_p), 32'd0);

        // Fault and recovery
        for (int i = 2; i <= 7; i++) tick(1'b1, 4'(i), 1'b0);
        tick(1'b1, 4'd9, 1'b0);
        cmp("fault_err", 32'(err), 32'd1);
        cmp("fault_state", 32'(state), 32'd3);
        tick(1'b1, 4'd12, 1'b0);
        cmp("fault_hold", 32'(state), 32'd3);
        tick(1'b1, 4'd10, 1'b1);
        cmp("clr_err", 32'(err), 32'd0);
        cmp("clr_state", 32'(state), 32'd1);
        for (int i = 11; i <= 13; i++) tick(1'b1, 4'(i), 1'b0);
        cmp("relock_pre", 32'(locked), 32'd0);
        tick(1'b1, 4'd14, 1'b0);
        cmp("relock", 32'(locked), 32'd1);

        // clr_err while locked is ignored; EN=0 holds everything
        tick(1'b1, 4'd15, 1'b1);
        cmp("clr_in_lock", 32'(state), 32'd2);
        tick(1'b0, 4'd3, 1'b0);
        cmp("en0_state", 32'(state), 32'd2);
        tick(1'b1, 4'd0, 1'b0);
        cmp("wrap_after_hold", 32'(wrap_p), 32'd1);
        for (int i = 1; i <= 5; i++) tick(1'b1, 4'(i), 1'b0);
        cmp("cnt3", 32'(match_cnt), 32'd3);
        cmp("cnt3_locked", 32'(locked), 32'd1);

        // Async reset between edges
        #1 rst_n = 1'b0;
        model_reset();
        #0.5;
        cmp("arst_state", 32'(state), 32'd0);
        cmp("arst_locked", 32'(locked), 32'd0);
        cmp("arst_match_p", 32'(match_p), 32'd0);
        cmp("arst_cnt", 32'(match_cnt), 32'd0);
        cmp("arst_err", 32'(err), 32'd0);
        cmp("arst_wrap", 32'(wrap_p), 32'd0);
        #0.5 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 4'($urandom_range(15, 0)), 1'b0);
            cmp("en0_idle", 32'(state), 32'd0);
            cmp("en0_pulse", 32'(match_p | wrap_p), 32'd0);
        end

        // Saturation with a repeated value
        #1 rst_n = 1'b0;
        model_reset();
        #1 rst_n = 1'b1;
        tick(1'b1, 4'd5, 1'b0);
        cmp("sat_first_mp", 32'(match_p), 32'd1);
        for (int i = 1; i < 300; i++) tick(1'b1, 4'd5, 1'b0);
        cmp("sat_cnt", 32'(match_cnt), 32'd255);
        cmp("sat_state", 32'(state), 32'd1);
        cmp("sat_mp", 32'(match_p), 32'd1);
        tick(1'b0, 4'd5, 1'b0);
        @(negedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
